// File: rtl/instr_mem_pkg.sv
// Shared constants for the instruction memory bank: opcodes, instruction
// word layout, peripheral select nibbles and special word indices.
package instr_mem_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IDX_W   = 12;

  // Execution-engine opcodes (top byte of an instruction word).
  typedef enum logic [7:0] {
    OP_MMULT     = 8'h00,
    OP_MADD      = 8'h01,
    OP_MSUB      = 8'h02,
    OP_MTRANS    = 8'h03,
    OP_MSCALE    = 8'h04,
    OP_MSCALEIMM = 8'h05,
    OP_IADD      = 8'h10,
    OP_ISUB      = 8'h11,
    OP_IMULT     = 8'h12,
    OP_IDIV      = 8'h13,
    OP_STOP      = 8'hFF
  } opcode_e;

  // Instruction word payload: opcode::dest::src1::src2.
  typedef struct packed {
    opcode_e    op;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_t;

  // Unwritten / out-of-range words decode as STOP.
  localparam logic [INSTR_W-1:0] STOP_WORD = 32'hFFFF_FFFF;

  // Peripheral select nibbles on address[15:12].
  localparam logic [3:0] SEL_MAIN  = 4'h0;
  localparam logic [3:0] SEL_INSTR = 4'h1;
  localparam logic [3:0] SEL_MALU  = 4'h2;
  localparam logic [3:0] SEL_IALU  = 4'h3;
  localparam logic [3:0] SEL_REG   = 4'h4;
  localparam logic [3:0] SEL_EXEC  = 4'h5;

  // Word index of the write-lock register.
  localparam logic [IDX_W-1:0] LOCK_IDX = 12'hFFF;

  // Pack an instruction word from its fields.
  function automatic logic [INSTR_W-1:0] make_instr(input opcode_e op,
                                                    input logic [7:0] dest,
                                                    input logic [7:0] src1,
                                                    input logic [7:0] src2);
    instr_t w;
    w.op   = op;
    w.dest = dest;
    w.src1 = src1;
    w.src2 = src2;
    return w;
  endfunction

endpackage

// File: rtl/instr_mem_rd_pipe.sv
// Read-data delay line: LAT stages of valid+data, async active-low reset.
// Data registers load only alongside a valid bit, so the last stage holds
// the most recent read result between reads.
//   clk, rst_n   : clock, async active-low reset
//   in_valid/data: read result entering the pipe
//   out_valid/data: result LAT clocks later
module instr_mem_rd_pipe #(
  parameter int unsigned LAT = 1,
  parameter int unsigned W   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] vld_q;
  logic [W-1:0]   dat_q [LAT];

  // Shift stages; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) dat_q[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/instr_mem_bank.sv
// Bus-writable instruction memory at peripheral nibble SELECT.
//   Clk, nReset : clock, async active-low reset
//   address     : [15:12] peripheral select, [11:0] word index
//   nRead/nWrite: active-low requests (both low = collision)
//   DataIn      : write data, low WORD_W bits used
//   DataOut     : read data, zero-extended, held between reads
//   DataValid   : one-cycle pulse with each new DataOut
//   AddrErr     : one-cycle pulse for out-of-range or collided access
//   Locked      : write-lock state (index 12'hFFF)
module instr_mem_bank
  import instr_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BUS_W  = 256,
  parameter logic [3:0]  SELECT = SEL_INSTR,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [15:0]      address,
  input  logic             nRead,
  input  logic             nWrite,
  input  logic [BUS_W-1:0] DataIn,
  output logic [BUS_W-1:0] DataOut,
  output logic             DataValid,
  output logic             AddrErr,
  output logic             Locked
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic              locked_q;
  logic              addr_err_q;

  logic [IDX_W-1:0]  idx;
  logic [AW-1:0]     widx;
  logic              hit;
  logic              in_range;
  logic              is_lock;
  logic              wr_acc;
  logic              rd_acc;
  logic              mem_we;
  logic              err_c;
  logic [WORD_W-1:0] rd_word;
  logic              pipe_valid;
  logic [WORD_W-1:0] pipe_data;

  // Address decode.
  assign idx      = address[IDX_W-1:0];
  assign widx     = idx[AW-1:0];
  assign hit      = (address[15:12] == SELECT);
  assign in_range = ({1'b0, idx} < DEPTH_L);
  assign is_lock  = (idx == LOCK_IDX);
  assign wr_acc   = hit && !nWrite;
  assign rd_acc   = hit && !nRead && nWrite;
  assign mem_we   = wr_acc && in_range && !locked_q;

  // Out-of-range access (lock index excluded) or read/write collision.
  assign err_c = hit && ((!nWrite && !nRead) ||
                         ((!nWrite || !nRead) && !in_range && !is_lock));

  // Read word from the array as it stands in the accept cycle.
  always_comb begin
    rd_word = WORD_W'(STOP_WORD);
    if (in_range)     rd_word = mem[widx];
    else if (is_lock) rd_word = WORD_W'(locked_q);
  end

  // Storage array; registers rather than a RAM macro so reset can clear it.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WORD_W'(STOP_WORD);
    end else if (mem_we) begin
      mem[widx] <= DataIn[WORD_W-1:0];
    end
  end

  // Lock register and error strobe.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      locked_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= err_c;
      if (wr_acc && is_lock) locked_q <= DataIn[0];
    end
  end

  instr_mem_rd_pipe #(
    .LAT (RD_LAT),
    .W   (WORD_W)
  ) u_rd_pipe (
    .clk       (Clk),
    .rst_n     (nReset),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  // Upper write-data bits carry nothing for this block.
  if (BUS_W > WORD_W) begin : g_unused_hi
    logic unused_data_hi;
    assign unused_data_hi = ^DataIn[BUS_W-1:WORD_W];
  end

  assign DataOut   = BUS_W'(pipe_data);
  assign DataValid = pipe_valid;
  assign AddrErr   = addr_err_q;
  assign Locked    = locked_q;

endmodule

// File: tb/tb_instr_mem_bank.sv
// Bench for instr_mem_bank: two instances (RD_LAT 1 and 2) share stimulus;
// expected reads and error pulses are queued when driven and matched as the
// DUTs produce them.
module tb_instr_mem_bank;
  import instr_mem_pkg::*;

  localparam int unsigned DEPTH = 16;

  typedef struct {
    int          due;
    logic [31:0] word;
  } sb_t;

  logic         Clk = 1'b0;
  logic         nReset;
  logic [15:0]  address;
  logic         nRead;
  logic         nWrite;
  logic [255:0] DataIn;
  logic [255:0] do1, do2;
  logic         dv1, dv2, ae1, ae2, lk1, lk2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sb_t q1[$];
  sb_t q2[$];
  int  eq[$];

  logic [31:0] mem_m [DEPTH];
  logic        locked_m;

  instr_mem_bank #(.DEPTH(DEPTH), .WORD_W(32), .BUS_W(256), .SELECT(4'h1), .RD_LAT(1)) u_dut1 (
    .Clk(Clk), .nReset(nReset), .address(address), .nRead(nRead), .nWrite(nWrite),
    .DataIn(DataIn), .DataOut(do1), .DataValid(dv1), .AddrErr(ae1), .Locked(lk1));

  instr_mem_bank #(.DEPTH(DEPTH), .WORD_W(32), .BUS_W(256), .SELECT(4'h1), .RD_LAT(2)) u_dut2 (
    .Clk(Clk), .nReset(nReset), .address(address), .nRead(nRead), .nWrite(nWrite),
    .DataIn(DataIn), .DataOut(do2), .DataValid(dv2), .AddrErr(ae2), .Locked(lk2));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard: match read results and error pulses on the falling edge.
  always @(negedge Clk) begin
    sb_t e;
    logic exp_err;
    if (nReset) begin
      if (dv1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL lat1_unexpected_valid cyc=%0d data=%h", cyc, do1[31:0]);
        end else begin
          e = q1.pop_front();
          if (e.due != cyc || do1 !== 256'(e.word)) begin
            errors++;
            $display("FAIL lat1_read cyc=%0d got=%h due=%0d exp=%h", cyc, do1, e.due, e.word);
          end
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL lat1_missing_valid cyc=%0d exp=%h", cyc, q1[0].word);
        void'(q1.pop_front());
      end
      if (dv2) begin
        checks++;
        if (q2.size() == 0) begin
          errors++;
          $display("FAIL lat2_unexpected_valid cyc=%0d data=%h", cyc, do2[31:0]);
        end else begin
          e = q2.pop_front();
          if (e.due != cyc || do2 !== 256'(e.word)) begin
            errors++;
            $display("FAIL lat2_read cyc=%0d got=%h due=%0d exp=%h", cyc, do2, e.due, e.word);
          end
        end
      end else if (q2.size() > 0 && q2[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL lat2_missing_valid cyc=%0d exp=%h", cyc, q2[0].word);
        void'(q2.pop_front());
      end
      exp_err = (eq.size() > 0 && eq[0] == cyc);
      if (exp_err) void'(eq.pop_front());
      checks++;
      if (ae1 !== exp_err || ae2 !== exp_err) begin
        errors++;
        $display("FAIL addr_err cyc=%0d got=%b/%b exp=%b", cyc, ae1, ae2, exp_err);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'hFFFF_FFFF;
    locked_m = 1'b0;
    q1.delete();
    q2.delete();
    eq.delete();
  endtask

  // One bus cycle: update the model, queue expectations, drive the pins.
  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d);
    logic [11:0] i;
    logic        h;
    logic        err;
    logic [31:0] w;
    @(negedge Clk);
    address = a;
    nRead   = !rd;
    nWrite  = !wr;
    DataIn  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, d};
    h   = (a[15:12] == 4'h1);
    i   = a[11:0];
    err = 1'b0;
    if (h && wr) begin
      if (i < DEPTH) begin
        if (!locked_m) mem_m[i[3:0]] = d;
      end else if (i == 12'hFFF) begin
        locked_m = d[0];
      end else begin
        err = 1'b1;
      end
      if (rd) err = 1'b1;
    end else if (h && rd) begin
      if (i < DEPTH) w = mem_m[i[3:0]];
      else if (i == 12'hFFF) w = {31'b0, locked_m};
      else begin
        w   = 32'hFFFF_FFFF;
        err = 1'b1;
      end
      q1.push_back('{due: cyc + 1, word: w});
      q2.push_back('{due: cyc + 2, word: w});
    end
    if (err) eq.push_back(cyc + 1);
    @(posedge Clk);
    #1;
    nRead  = 1'b1;
    nWrite = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 16'h0000, 32'h0);
  endtask

  task automatic test_reset();
    nReset  = 1'b1;
    nRead   = 1'b1;
    nWrite  = 1'b1;
    address = '0;
    DataIn  = '0;
    model_reset();
    #3 nReset = 1'b0;
    #1;
    checks++;
    if (do1 !== '0 || do2 !== '0 || dv1 !== 1'b0 || dv2 !== 1'b0 ||
        ae1 !== 1'b0 || ae2 !== 1'b0 || lk1 !== 1'b0 || lk2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got dv=%b%b ae=%b%b lk=%b%b do=%h/%h exp all zero",
               dv1, dv2, ae1, ae2, lk1, lk2, do1[31:0], do2[31:0]);
    end
    @(negedge Clk);
    @(negedge Clk);
    nReset = 1'b1;
    drive(1'b1, 1'b0, 16'h1000, 32'h0);
    drive(1'b1, 1'b0, 16'h1001, 32'h0);
    drive(1'b1, 1'b0, 16'h1000 + 16'(DEPTH - 1), 32'h0);
    idle(3);
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 16'h1000, make_instr(OP_MADD, 8'h02, 8'h00, 8'h01));
    drive(1'b0, 1'b1, 16'h100F, make_instr(OP_IDIV, 8'h0B, 8'h0A, 8'h81));
    drive(1'b0, 1'b1, 16'h2000, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 16'h1000, 32'h0);
    drive(1'b1, 1'b0, 16'h100F, 32'h0);
    drive(1'b1, 1'b0, 16'h2000, 32'h0);
    drive(1'b0, 1'b1, 16'h1005, 32'hCAFE_0005);
    drive(1'b1, 1'b0, 16'h1005, 32'h0);
    idle(3);
    checks++;
    if (mem_m[0] !== 32'h0102_0001 || mem_m[15] !== 32'h130B_0A81) begin
      errors++;
      $display("FAIL instr_pack got=%h/%h exp=01020001/130b0a81", mem_m[0], mem_m[15]);
    end
  endtask

  task automatic test_lock();
    drive(1'b0, 1'b1, 16'h1FFF, 32'h1);
    @(negedge Clk);
    checks++;
    if (lk1 !== 1'b1 || lk2 !== 1'b1) begin
      errors++;
      $display("FAIL lock_set got=%b/%b exp=1", lk1, lk2);
    end
    drive(1'b1, 1'b0, 16'h1FFF, 32'h0);
    drive(1'b0, 1'b1, 16'h1003, 32'h1234_5678);
    drive(1'b1, 1'b0, 16'h1003, 32'h0);
    drive(1'b0, 1'b1, 16'h1FFF, 32'h0);
    @(negedge Clk);
    checks++;
    if (lk1 !== 1'b0 || lk2 !== 1'b0) begin
      errors++;
      $display("FAIL lock_clear got=%b/%b exp=0", lk1, lk2);
    end
    drive(1'b0, 1'b1, 16'h1003, 32'h1234_5678);
    drive(1'b1, 1'b0, 16'h1003, 32'h0);
    drive(1'b1, 1'b0, 16'h1FFF, 32'h0);
    idle(3);
  endtask

  task automatic test_addr_err();
    drive(1'b1, 1'b0, 16'h1010, 32'h0);
    drive(1'b0, 1'b1, 16'h1010, 32'h5555_5555);
    drive(1'b0, 1'b1, 16'h1FFE, 32'h5555_5555);
    idle(2);
    drive(1'b1, 1'b1, 16'h1002, 32'h0000_00AA);
    @(negedge Clk);
    checks++;
    if (ae1 !== 1'b1 || dv1 !== 1'b0) begin
      errors++;
      $display("FAIL collision got ae=%b dv=%b exp ae=1 dv=0", ae1, dv1);
    end
    drive(1'b1, 1'b0, 16'h1002, 32'h0);
    drive(1'b1, 1'b0, 16'h1000, 32'h0);
    idle(3);
  endtask

  task automatic test_back_to_back_reset();
    drive(1'b0, 1'b1, 16'h1FFF, 32'h1);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 16'h1000 + 16'(k), 32'h0);
    @(negedge Clk);
    #2;
    nReset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (do1 !== '0 || do2 !== '0 || dv1 !== 1'b0 || dv2 !== 1'b0 || lk1 !== 1'b0 || lk2 !== 1'b0) begin
      errors++;
      $display("FAIL kill_reset got dv=%b%b lk=%b%b do=%h/%h exp all zero",
               dv1, dv2, lk1, lk2, do1[31:0], do2[31:0]);
    end
    @(negedge Clk);
    @(negedge Clk);
    checks++;
    if (dv2 !== 1'b0) begin
      errors++;
      $display("FAIL killed_read_valid got=%b exp=0", dv2);
    end
    nReset = 1'b1;
    idle(2);
    for (int k = 0; k < DEPTH; k++) drive(1'b1, 1'b0, 16'h1000 + 16'(k), 32'h0);
    drive(1'b1, 1'b0, 16'h1FFF, 32'h0);
    idle(4);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_lock();
    test_addr_err();
    test_back_to_back_reset();
    checks++;
    if (q1.size() != 0 || q2.size() != 0 || eq.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d/%0d pending exp=0", q1.size(), q2.size(), eq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
